receptor_serial: RTL
====================

RECEPTOR_SERIAL -- requirements
Module: receptor_serial

Interface
REQ-001 Parameter: CICLOS_BIT, default 4, clock cycles per serial bit; SHALL be even and >= 2.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  reset, synchronous and active-high.
REQ-004 Port: rx  input  1  serial line, idle high, synchronous to clk (no internal synchronizer).
REQ-005 Port: palavra  output  6  last good frame: [5:1] character (first data bit received in [5]), [0] received parity bit; format consumed unchanged by the downstream parity-verification stage.
REQ-006 Port: valido  output  1  one-cycle pulse, palavra updated with a good-stop frame.
REQ-007 Port: erro_quadro  output  1  one-cycle pulse, stop bit sampled low.
REQ-008 Port: ocupado  output  1  high whenever FSM is not OCIOSO.

Function
REQ-009 Frame SHALL be: start (0), 5 data bits, 1 parity bit, stop (1); each bit CICLOS_BIT cycles long.
REQ-010 FSM states SHALL be OCIOSO, INICIO, DADOS, PARIDADE, PARADA.
REQ-011 Bit counter cnt and data-bit index idx SHALL be zeroed on every state entry.
REQ-012 OCIOSO: rx sampled 0 at edge k -> INICIO at edge k; otherwise stay.
REQ-013 INICIO: cnt increments each edge until cnt == CICLOS_BIT/2-1; at that edge rx resampled: 0 -> DADOS, 1 -> OCIOSO (false start, no pulses).
REQ-014 Start mid-sample therefore SHALL occur at edge k+CICLOS_BIT/2.
REQ-015 DADOS/PARIDADE/PARADA: cnt counts 0..CICLOS_BIT-1; sample rx at the edge where cnt == CICLOS_BIT-1, then cnt wraps to 0.
REQ-016 Data bit i (1..5) SHALL be sampled at edge k+CICLOS_BIT/2+i*CICLOS_BIT into an internal shift register; after bit 5 -> PARIDADE.
REQ-017 Parity bit SHALL be sampled at edge k+CICLOS_BIT/2+6*CICLOS_BIT -> PARADA; no parity checking is done in this block.
REQ-018 Stop bit SHALL be sampled at edge S = k+CICLOS_BIT/2+7*CICLOS_BIT; FSM -> OCIOSO at S.
REQ-019 Stop = 1: at edge S palavra loads {data[5:1], parity}; valido = 1 for exactly the cycle after S.
REQ-020 Stop = 0: palavra unchanged; erro_quadro = 1 for exactly the cycle after S; valido stays 0.
REQ-021 valido and erro_quadro SHALL never be high together and SHALL be registered outputs.
REQ-022 palavra SHALL hold its value between good frames.
REQ-023 ocupado SHALL be combinational from state (0 only in OCIOSO).
REQ-024 A new start may be detected at edge S+1 or later; back-to-back frames SHALL be received without loss.
REQ-025 rx activity while not in OCIOSO SHALL only be observed at the defined sample edges.

Reset
REQ-026 reset high at an edge SHALL force state OCIOSO, cnt = 0, idx = 0, shift register = 0, palavra = 6'b000000, valido = 0, erro_quadro = 0; ocupado = 0 follows.
REQ-027 reset SHALL take priority over all other events, including a stop-bit sample at the same edge (no pulse, palavra not loaded).
REQ-028 A frame interrupted by reset SHALL be discarded; reception resumes with the next start detected after reset deasserts.

Verification (CICLOS_BIT = 4; rx first low at edge 0, so S = 30)
REQ-029 Reset held 2 cycles, rx = 1 -> palavra = 000000, valido = erro_quadro = ocupado = 0.
REQ-030 Frame data 1,0,1,1,0, parity 1, stop 1 -> palavra = 6'b101101 after edge 30, valido = 1 in cycle 30-31 only, ocupado 0 from edge 30.
REQ-031 rx low for edge 0 only, high from edge 1 -> return to OCIOSO at edge 2, no valido/erro_quadro, palavra unchanged.
REQ-032 After REQ-030, frame 0,0,0,0,1 parity 1 with stop 0 -> erro_quadro = 1 in cycle 30-31, palavra stays 6'b101101.
REQ-033 reset pulsed at edge 12 mid-DADOS -> OCIOSO, palavra = 000000, no pulse at edge 30; next full frame 1,1,1,1,1 parity 1 -> palavra = 6'b111111, valido once.
REQ-034 Back-to-back frames 0,0,0,0,0/0 then 1,1,1,1,1/1, second start low at edge 32 -> palavra 000000 (valido after edge 30) then 111111 (valido after edge 62).

Source files
------------

// File: rtl/receptor_serial.sv
// Serial frame receiver: start, 5 data bits, parity bit, stop; CICLOS_BIT clocks per bit.
// Samples each bit at its midpoint and presents {data, parity} on palavra after a good stop.
module receptor_serial #(
   parameter int unsigned CICLOS_BIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [5:0] palavra,
   output logic       valido,
   output logic       erro_quadro,
   output logic       ocupado
);

   localparam int unsigned METADE = CICLOS_BIT / 2;
   localparam int unsigned CW     = $clog2(CICLOS_BIT);
   localparam int unsigned NDADOS = 5;

   typedef enum logic [2:0] {
      OCIOSO,
      INICIO,
      DADOS,
      PARIDADE,
      PARADA
   } estado_t;

   estado_t         estado, estado_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [2:0]      idx, idx_n;
   logic [4:0]      dados, dados_n;
   logic            paridade, paridade_n;
   logic [5:0]      palavra_n;
   logic            valido_n, erro_quadro_n;
   logic            fim_bit;

   // State and output registers; reset wins over every other event
   always_ff @(posedge clk) begin
      if (reset) begin
         estado      <= OCIOSO;
         cnt         <= '0;
         idx         <= '0;
         dados       <= '0;
         paridade    <= 1'b0;
         palavra     <= '0;
         valido      <= 1'b0;
         erro_quadro <= 1'b0;
      end else begin
         estado      <= estado_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         dados       <= dados_n;
         paridade    <= paridade_n;
         palavra     <= palavra_n;
         valido      <= valido_n;
         erro_quadro <= erro_quadro_n;
      end
   end

   assign fim_bit = (cnt == CW'(CICLOS_BIT - 1));

   // Next-state and sampling logic; rx only matters at the bit-midpoint edges
   always_comb begin
      estado_n      = estado;
      cnt_n         = cnt;
      idx_n         = idx;
      dados_n       = dados;
      paridade_n    = paridade;
      palavra_n     = palavra;
      valido_n      = 1'b0;
      erro_quadro_n = 1'b0;
      unique case (estado)
         OCIOSO: begin
            if (!rx) begin
               estado_n = INICIO;
               cnt_n    = '0;
               idx_n    = '0;
            end
         end
         INICIO: begin
            if (cnt == CW'(METADE - 1)) begin
               cnt_n    = '0;
               idx_n    = '0;
               estado_n = rx ? OCIOSO : DADOS;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DADOS: begin
            if (fim_bit) begin
               cnt_n   = '0;
               dados_n = {dados[3:0], rx};
               if (idx == 3'(NDADOS - 1)) begin
                  idx_n    = '0;
                  estado_n = PARIDADE;
               end else begin
                  idx_n = idx + 3'd1;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         PARIDADE: begin
            if (fim_bit) begin
               cnt_n      = '0;
               idx_n      = '0;
               paridade_n = rx;
               estado_n   = PARADA;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         PARADA: begin
            if (fim_bit) begin
               cnt_n    = '0;
               idx_n    = '0;
               estado_n = OCIOSO;
               if (rx) begin
                  palavra_n = {dados, paridade};
                  valido_n  = 1'b1;
               end else begin
                  erro_quadro_n = 1'b1;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: begin
            estado_n = OCIOSO;
            cnt_n    = '0;
            idx_n    = '0;
         end
      endcase
   end

   assign ocupado = (estado != OCIOSO);

endmodule
